// File: rtl/tick_phase_acc_pkg.sv
// Shared defaults and types for the tick-driven phase accumulator.
package tick_phase_acc_pkg;

  localparam int unsigned DEF_PHASE_WIDTH = 32;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;

  typedef logic [DEF_PHASE_WIDTH-1:0] phase_t;

endpackage : tick_phase_acc_pkg

// File: rtl/tick_phase_acc_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and registered pointers.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LVL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic [LVL_WIDTH-1:0] level,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_WIDTH-1:0] level_q, level_d;
  logic                 do_push;
  logic                 do_pop;

  assign full  = (level_q == LVL_WIDTH'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers and occupancy.
  // When full with push+pop, wr_ptr equals rd_ptr: the write lands in the slot
  // being vacated, which is safe because the read pointer moves past it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_WIDTH'(1);
      2'b01:   level_d = level_q - LVL_WIDTH'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are meaningless while empty so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : sync_fifo

// File: rtl/tick_phase_acc.sv
// Tick-driven phase accumulator: each accepted tick pushes the current phase
// into an output FIFO and advances the phase by phase_inc. Samples that find
// the FIFO full are dropped and flagged through a sticky overflow bit.
module tick_phase_acc
  import tick_phase_acc_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned LVL_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   tick,
  input  logic [PHASE_WIDTH-1:0] phase_inc,
  input  logic                   clr_ovf,
  output logic [PHASE_WIDTH-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LVL_WIDTH-1:0]   level,
  output logic                   overflow
);

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   overflow_q, overflow_d;
  logic                   accept;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Head validity comes straight from registered occupancy, never from m_ready.
  assign m_valid  = ~fifo_empty;
  assign overflow = overflow_q;

  assign accept = tick & en;
  assign pop    = m_valid & m_ready;
  assign push   = accept & (~fifo_full | pop);
  assign drop   = accept & fifo_full & ~pop;

  // Phase advance and sticky overflow next-state; a new drop beats clr_ovf.
  always_comb begin
    phase_d    = phase_q;
    overflow_d = overflow_q;
    if (accept) begin
      phase_d = phase_q + phase_inc;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Accumulator and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH     (PHASE_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .LVL_WIDTH (LVL_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (phase_q),
    .dout  (m_data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule : tick_phase_acc

// File: doc/tick_phase_acc.md
Name: tick_phase_acc

Overview:
- Tick-driven phase accumulator that consumes the single-cycle terminal-count strobe from the programmable period counter.
- Each strobe is one sample tick. On every accepted tick the block emits the current phase on a valid/ready stream, then advances the phase by a programmable increment.
- A small output FIFO absorbs downstream backpressure. Dropped samples are reported through a sticky overflow flag.
- Sits between the rate generator and NCO/LUT or DSP consumers.

Parameters:
- PHASE_WIDTH, 32, width of the phase accumulator and of the output data.
- FIFO_DEPTH, 4, output buffer depth. Must be a power of 2 and at least 2.
- LVL_WIDTH, $clog2(FIFO_DEPTH)+1, width of the level output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  accumulator enable. When low, ticks are ignored entirely.
- tick  in  1  one-cycle sample strobe from the period counter
- phase_inc  in  PHASE_WIDTH  increment, sampled in the tick cycle
- clr_ovf  in  1  clears the sticky overflow flag
- m_data  out  PHASE_WIDTH  phase sample at the FIFO head
- m_valid  out  1  m_data is valid
- m_ready  in  1  consumer accepts the sample
- level  out  LVL_WIDTH  current FIFO occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: set when a tick was dropped

Behaviour:
- Reset (rst=1 at a clk edge):
  - phase=0, FIFO emptied, m_valid=0, level=0, overflow=0.
  - m_data value is don't-care while m_valid=0.
  - Reset mid-operation discards all buffered samples. A tick in the reset cycle is ignored.
- Accepted tick (tick & en):
  - The push value is the pre-increment phase, so the first sample after reset is 0.
  - phase <= phase + phase_inc, modulo 2^PHASE_WIDTH, unsigned wrap with no saturation.
  - phase_inc changes take effect on the next tick only.
- Phase advance is independent of FIFO space. When a sample is dropped, phase still advances.
- Pop: a pop occurs when m_valid & m_ready.
- Push: a push occurs on an accepted tick when (level < FIFO_DEPTH) or a pop happens in the same cycle.
  - Full FIFO with simultaneous push and pop: level is unchanged and the push is accepted.
- Drop: accepted tick & level==FIFO_DEPTH & no pop.
  - The sample is discarded and overflow <= 1 on the next edge.
  - Set has priority over clr_ovf in the same cycle.
- Latency: a tick at edge N, with FIFO empty, gives m_valid=1 and m_data=sample after edge N. Tick to output is 1 cycle.
- Stream rules:
  - m_data and m_valid are held stable while m_valid & !m_ready.
  - m_valid does not depend combinationally on m_ready.
  - Ordering is strict FIFO.
- level: registered, updated every edge as +1 push, -1 pop, 0 for both or neither.
- Empty with simultaneous push and pop: cannot occur because m_valid=0. The push lands and the head becomes valid next cycle.
- en low: no push, phase holds. The FIFO still drains.
- tick held high for several cycles: each cycle counts as a separate tick. The period counter guarantees single-cycle pulses; this block does not edge-detect.

Decomposition:
- Package tick_phase_acc_pkg:
  - default PHASE_WIDTH and FIFO_DEPTH constants
  - typedef phase_t = logic [PHASE_WIDTH-1:0]
- Sub-module sync_fifo, parameterized on WIDTH and DEPTH:
  - Ports: push/pop, din/dout, level, full, empty.
  - Registered read pointer, first-word-fall-through head.
- Top level contains the accumulator, push/drop/overflow logic and the sync_fifo instance.

Test Plan:
- Reset, en=1, phase_inc=0x10, 4 ticks spaced 5 cycles, m_ready=1 -> m_data sequence 0x00, 0x10, 0x20, 0x30. Each m_valid pulse comes 1 cycle after its tick; overflow=0.
- Wrap: phase_inc=0x4000_0000, 5 ticks -> 0x0, 0x40000000, 0x80000000, 0xC0000000, 0x0.
- Backpressure: m_ready=0, phase_inc=1, 6 ticks, DEPTH=4 -> level=4, overflow=1, m_data held at 0. Then m_ready=1 -> outputs 0, 1, 2, 3, level back to 0. The next tick emits 6 (samples 4 and 5 were dropped).
- Full with same-cycle pop: level=4, tick together with m_ready=1 -> level stays 4, no overflow, new sample is last in the queue.
- Overflow priority: overflow event and clr_ovf=1 in the same cycle -> overflow=1. clr_ovf alone on the next cycle -> overflow=0.
- Reset mid-stream: level=3, rst=1 for 1 cycle -> m_valid=0, level=0, next emitted sample is 0. en=0 with ticks -> no output, and phase resumes from its held value when en=1.
